// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pixel pipeline: active-area defaults, colour
// format, pattern mode encoding and fixed colours.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int RGB_W        = 3;

  typedef enum logic [1:0] {
    MODE_BARS    = 2'd0,
    MODE_CHECKER = 2'd1,
    MODE_BOX     = 2'd2,
    MODE_SOLID   = 2'd3
  } mode_t;

  typedef struct packed {
    logic [RGB_W-1:0] r;
    logic [RGB_W-1:0] g;
    logic [RGB_W-1:0] b;
  } rgb_t;

  localparam rgb_t BLACK   = '{r: '0, g: '0, b: '0};
  localparam rgb_t WHITE   = '{r: '1, g: '1, b: '1};
  localparam rgb_t BG_BLUE = '{r: '0, g: '0, b: 3'b100};

  function automatic mode_t mode_succ(input mode_t m);
    return mode_t'(m + 2'd1);
  endfunction

endpackage

// File: rtl/vga_box_mover.sv
// Position and direction of the bouncing box; moves one pixel per axis on
// each enabled frame tick.
module vga_box_mover
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int CNT_W    = 10,
  parameter int BOX_SIZE = 32
) (
  input  logic             clk_pix,
  input  logic             resetn,
  input  logic             tick,
  input  logic             en,
  output logic [CNT_W-1:0] box_x,
  output logic [CNT_W-1:0] box_y
);

  localparam int X_LIM = H_ACTIVE - BOX_SIZE;
  localparam int Y_LIM = V_ACTIVE - BOX_SIZE;
  localparam logic [CNT_W-1:0] X_MAX = X_LIM[CNT_W-1:0];
  localparam logic [CNT_W-1:0] Y_MAX = Y_LIM[CNT_W-1:0];
  localparam logic [CNT_W-1:0] STEP  = CNT_W'(1);

  logic             x_dec, y_dec;
  logic             x_dec_nxt, y_dec_nxt;
  logic [CNT_W-1:0] x_nxt, y_nxt;

  // A direction reversal consumes the frame: the position holds while the
  // sign flips, so the box sits on the edge for two consecutive frames.
  function automatic void bounce(input  logic [CNT_W-1:0] pos,
                                 input  logic             dec,
                                 input  logic [CNT_W-1:0] lim,
                                 output logic [CNT_W-1:0] pos_n,
                                 output logic             dec_n);
    pos_n = pos;
    dec_n = dec;
    if (dec) begin
      if (pos == '0) dec_n = 1'b0;
      else           pos_n = pos - STEP;
    end else begin
      if (pos >= lim) dec_n = 1'b1;
      else            pos_n = pos + STEP;
    end
  endfunction

  always_comb begin
    x_nxt     = box_x;
    y_nxt     = box_y;
    x_dec_nxt = x_dec;
    y_dec_nxt = y_dec;
    if (tick && en) begin
      bounce(box_x, x_dec, X_MAX, x_nxt, x_dec_nxt);
      bounce(box_y, y_dec, Y_MAX, y_nxt, y_dec_nxt);
    end
  end

  always_ff @(posedge clk_pix or negedge resetn) begin
    if (!resetn) begin
      box_x <= '0;
      box_y <= '0;
      x_dec <= 1'b0;
      y_dec <= 1'b0;
    end else begin
      box_x <= x_nxt;
      box_y <= y_nxt;
      x_dec <= x_dec_nxt;
      y_dec <= y_dec_nxt;
    end
  end

endmodule

// File: rtl/vga_pattern_gen.sv
// Two-stage test-pattern pixel source behind vga_timing; sync and de are
// delayed to stay aligned with RGB. Define VGA_PAT_GRID_EN for a red grid overlay.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int CNT_W    = 10,
  parameter int BOX_SIZE = 32
`ifdef VGA_PAT_GRID_EN
  ,
  parameter int GRID_SHIFT = 6
`endif
) (
  input  logic             clk_pix,
  input  logic             resetn,
  input  logic [CNT_W-1:0] hcount_i,
  input  logic [CNT_W-1:0] vcount_i,
  input  logic             hsync_i,
  input  logic             vsync_i,
  input  logic             de_i,
  input  logic             mode_next,
  output logic [RGB_W-1:0] rgb_r,
  output logic [RGB_W-1:0] rgb_g,
  output logic [RGB_W-1:0] rgb_b,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic             de_o,
  output logic             frame_tick,
  output logic [1:0]       mode_o
);

  localparam int BAR_W = H_ACTIVE / 8;
  localparam logic [CNT_W-1:0] TICK_LINE = V_ACTIVE[CNT_W-1:0];
  localparam logic [CNT_W:0]   BOX_SPAN  = BOX_SIZE[CNT_W:0];

  mode_t            mode, mode_nxt;
  logic             pending, pending_nxt;
  logic             tick;
  logic             box_en;
  logic [7:0]       frm_cnt;
  logic [CNT_W-1:0] box_x, box_y;

  logic [CNT_W-1:0] h1, v1;
  logic             hs1, vs1, de1, tick1;
  logic [2:0]       bar;
  logic             in_box;
  rgb_t             pattern, pixel;

  rgb_t             rgb2;
  logic             hs2, vs2, de2, tick2;

  // First blanking line, column 0: the only place frame state may change.
  assign tick = (hcount_i == '0) && (vcount_i == TICK_LINE);

  always_ff @(posedge clk_pix or negedge resetn) begin
    if (!resetn) begin
      mode    <= MODE_BARS;
      pending <= 1'b0;
    end else begin
      mode    <= mode_nxt;
      pending <= pending_nxt;
    end
  end

  // A request on the tick cycle itself is merged before the tick decision.
  always_comb begin
    mode_nxt    = mode;
    pending_nxt = pending | mode_next;
    if (tick && pending_nxt) begin
      mode_nxt    = mode_succ(mode);
      pending_nxt = 1'b0;
    end
  end

  always_comb begin
    mode_o = mode;
    box_en = (mode == MODE_BOX);
  end

  always_ff @(posedge clk_pix or negedge resetn) begin
    if (!resetn)   frm_cnt <= '0;
    else if (tick) frm_cnt <= frm_cnt + 8'd1;
  end

  vga_box_mover #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .CNT_W    (CNT_W),
    .BOX_SIZE (BOX_SIZE)
  ) u_box_mover (
    .clk_pix (clk_pix),
    .resetn  (resetn),
    .tick    (tick),
    .en      (box_en),
    .box_x   (box_x),
    .box_y   (box_y)
  );

  always_ff @(posedge clk_pix or negedge resetn) begin
    if (!resetn) begin
      h1    <= '0;
      v1    <= '0;
      hs1   <= 1'b0;
      vs1   <= 1'b0;
      de1   <= 1'b0;
      tick1 <= 1'b0;
    end else begin
      h1    <= hcount_i;
      v1    <= vcount_i;
      hs1   <= hsync_i;
      vs1   <= vsync_i;
      de1   <= de_i;
      tick1 <= tick;
    end
  end

  // Bar index from rising thresholds; the last threshold passed wins.
  always_comb begin
    bar = '0;
    for (int unsigned k = 1; k < 8; k++) begin
      if (32'(h1) >= k * BAR_W) bar = 3'(k);
    end
  end

  assign in_box = ({1'b0, h1} >= {1'b0, box_x}) && ({1'b0, h1} < {1'b0, box_x} + BOX_SPAN) &&
                  ({1'b0, v1} >= {1'b0, box_y}) && ({1'b0, v1} < {1'b0, box_y} + BOX_SPAN);

  always_comb begin
    pattern = BLACK;
    unique case (mode)
      MODE_BARS:    pattern = '{r: {RGB_W{bar[2]}}, g: {RGB_W{bar[1]}}, b: {RGB_W{bar[0]}}};
      MODE_CHECKER: pattern = (h1[5] ^ v1[5]) ? WHITE : BLACK;
      MODE_BOX:     pattern = in_box ? WHITE : BG_BLUE;
      MODE_SOLID:   pattern = '{r: frm_cnt[7:5], g: frm_cnt[6:4], b: frm_cnt[5:3]};
      default:      pattern = BLACK;
    endcase
  end

`ifdef VGA_PAT_GRID_EN
  localparam rgb_t GRID_RED = '{r: '1, g: '0, b: '0};
  logic grid_hit;
  assign grid_hit = (h1[GRID_SHIFT-1:0] == '0) || (v1[GRID_SHIFT-1:0] == '0);
  assign pixel    = grid_hit ? GRID_RED : pattern;
`else
  assign pixel = pattern;
`endif

  always_ff @(posedge clk_pix or negedge resetn) begin
    if (!resetn) begin
      rgb2  <= BLACK;
      hs2   <= 1'b0;
      vs2   <= 1'b0;
      de2   <= 1'b0;
      tick2 <= 1'b0;
    end else begin
      rgb2  <= de1 ? pixel : BLACK;
      hs2   <= hs1;
      vs2   <= vs1;
      de2   <= de1;
      tick2 <= tick1;
    end
  end

  assign rgb_r      = rgb2.r;
  assign rgb_g      = rgb2.g;
  assign rgb_b      = rgb2.b;
  assign hsync_o    = hs2;
  assign vsync_o    = vs2;
  assign de_o       = de2;
  assign frame_tick = tick2;

endmodule

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
- Pixel-source stage directly downstream of the vga_timing generator and upstream of the RGB/sync output pins in vga_top.
- Consumes hcount/vcount/hsync/vsync/de and produces 3-3-3 RGB from a selectable test pattern.
- Delays sync and de by the same amount so all outputs stay cycle-aligned.
- Mode changes and animation updates are applied only at frame boundaries, so no tearing occurs.

Parameters:
- H_ACTIVE, 640, visible pixels per line.
- V_ACTIVE, 480, visible lines per frame.
- CNT_W, 10, width of the hcount and vcount inputs.
- BOX_SIZE, 32, side length in pixels of the moving box.
- GRID_SHIFT, 6, log2 of the grid pitch for the optional overlay (pitch 64 px).

Ports:
- clk_pix  in  1  pixel clock, ~25 MHz.
- resetn  in  1  asynchronous active-low reset.
- hcount_i  in  CNT_W  horizontal pixel counter from vga_timing.
- vcount_i  in  CNT_W  vertical line counter from vga_timing.
- hsync_i  in  1  horizontal sync from vga_timing, passed through with its polarity unchanged.
- vsync_i  in  1  vertical sync from vga_timing, passed through with its polarity unchanged.
- de_i  in  1  display enable from vga_timing.
- mode_next  in  1  single-cycle request to advance to the next pattern.
- rgb_r  out  3  red.
- rgb_g  out  3  green.
- rgb_b  out  3  blue.
- hsync_o  out  1  hsync_i delayed 2 cycles.
- vsync_o  out  1  vsync_i delayed 2 cycles.
- de_o  out  1  de_i delayed 2 cycles.
- frame_tick  out  1  one-cycle pulse at each frame boundary.
- mode_o  out  2  current pattern mode.

Behaviour:
- Clock and reset: single clock, clk_pix. Reset resetn is asynchronous, active-low.
- Reset values:
  - All outputs 0; mode_o = BARS (0).
  - Box position (0,0), direction dx=+1, dy=+1.
  - pending request cleared; frame counter frm_cnt (8b) = 0.
- Pipeline, fixed 2-cycle latency:
  - S1 registers the inputs and computes the pattern fields.
  - S2 registers the RGB and the delayed hsync/vsync/de.
  - Every output relates to the inputs from 2 cycles earlier.
- Blanking: when de in the S2 stage is 0, RGB = 0 regardless of mode.
- Frame boundary:
  - Internal tick fires when hcount_i==0 and vcount_i==V_ACTIVE, i.e. the first blanking line.
  - frame_tick is that tick delayed to S2 alignment; exactly 1 cycle per frame.
- Mode FSM: BARS(0) -> CHECKER(1) -> BOX(2) -> SOLID(3) -> BARS.
  - A mode_next pulse sets pending.
  - At the tick, if pending is set: mode advances and pending clears.
  - Multiple pulses within one frame collapse into a single advance.
  - A pulse in the same cycle as the tick is honoured at that tick.
  - A pulse arriving after the tick waits for the next frame.
- Pattern rules (h = hcount, v = vcount):
  - BARS:
    - Bar index i = h / (H_ACTIVE/8), computed with a constant comparator chain (no divider).
    - r = {3{i[2]}}, g = {3{i[1]}}, b = {3{i[0]}}.
    - i=0 is black, i=7 is white.
  - CHECKER: white (all 3'b111) when h[5]^v[5] is 1, else black.
  - BOX:
    - Inside the box (box_x <= h < box_x+BOX_SIZE and box_y <= v < box_y+BOX_SIZE): white.
    - Outside the box: background r=0, g=0, b=3'b100.
  - SOLID: r=frm_cnt[7:5], g=frm_cnt[6:4], b=frm_cnt[5:3].
- Frame counter: frm_cnt increments at each tick and wraps 255 -> 0.
- Box motion, updated at the tick only and only while in BOX mode:
  - box_x += dx.
  - If the next box_x + BOX_SIZE would exceed H_ACTIVE, or box_x would go below 0: dx is negated and box_x is left unchanged that frame.
  - box_y follows the same rule against V_ACTIVE.
  - Box position is held when not in BOX mode.
- Reset mid-frame: takes effect immediately. RGB goes to 0 and the pipeline is flushed; correct frame alignment resumes from the first tick after reset.

Optional Feature:
- Macro: VGA_PAT_GRID_EN.
- Defined:
  - A red grid overlay (r=3'b111, g=0, b=0) drawn where h[GRID_SHIFT-1:0]==0 or v[GRID_SHIFT-1:0]==0.
  - Applies in all modes, during active video only.
  - Latency is unchanged at 2 cycles.
- Undefined: no overlay logic is synthesised; output is the pure pattern.

Decomposition:
- Shared package vga_pkg:
  - H_ACTIVE and V_ACTIVE defaults.
  - RGB_W = 3.
  - 2-bit mode encoding: MODE_BARS, MODE_CHECKER, MODE_BOX, MODE_SOLID.
  - Colour constants: BLACK, WHITE, BG_BLUE.
- One natural sub-module: vga_box_mover. It holds box_x/box_y and dx/dy, updates on the tick, and takes an enable input driven by the BOX mode.

Test Plan:
- Reset release, then feed a full 800x525 frame in BARS mode -> at h=0..79 RGB=000/000/000; at h=560..639 RGB=111/111/111; each output appears exactly 2 cycles after its input; RGB=0 whenever de_o=0.
- Three mode_next pulses within one frame -> mode_o goes 0 -> 1 only, at the tick; one frame_tick pulse is seen.
- mode_next in the same cycle as the tick -> mode advances at that tick; mode_next one cycle after the tick -> mode advances one frame later.
- BOX mode for 610 frames with H_ACTIVE=640, BOX_SIZE=32 -> box_x reaches 608, then dx flips and box_x decrements; box_y bounces at 448.
- Assert resetn low at h=300, v=200 -> all outputs 0 immediately; after release, mode_o=0 and the box is back at (0,0).
- Build with VGA_PAT_GRID_EN defined, CHECKER mode -> pixels at h=64 and v=128 are RGB=111/000/000. Built without the macro, the same pixels follow the checker pattern.
